// File: rtl/voice_wave_sched.sv
// Voice FIFO sequencer: record streaming and ping-pong playback buffer.
// Optional: VOICE_SCHED_LOOP_EN rewinds and replays at end of data.
module voice_wave_sched #(
  parameter int WAVE_SIZE  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int RD_TIMEOUT = 256,
  parameter int CNT_W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_rec,
  input  logic                  i_cmd_play,
  input  logic                  i_cmd_stop,
  input  logic                  i_rec_valid,
  input  logic [DATA_WIDTH-1:0] i_rec_data,
  output logic                  o_rec_ready,
  input  logic                  i_play_tick,
  output logic [DATA_WIDTH-1:0] o_play_data,
  output logic                  o_busy,
  output logic                  o_play_end,
  output logic [CNT_W-1:0]      o_ovr_cnt,
  output logic [CNT_W-1:0]      o_udr_cnt,
  output logic                  o_f_wr,
  output logic [DATA_WIDTH-1:0] o_f_wr_data,
  input  logic                  i_f_cach_full,
  output logic                  o_f_rd,
  output logic                  o_f_cls_raddr,
  input  logic [DATA_WIDTH-1:0] i_f_rd_data,
  input  logic                  i_f_rd_ef,
  input  logic                  i_f_rd_done
);
  localparam int AW = $clog2(WAVE_SIZE);
  localparam int TW = $clog2(RD_TIMEOUT);
  localparam int W1 = AW + 1;
  localparam logic [AW:0]   WS_C   = W1'(WAVE_SIZE);
  localparam logic [TW-1:0] TO_MAX = TW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_REWIND, S_PLAY} state_t;

  state_t                state_q, state_d;
  logic [1:0]            rw_q, rw_d;
  logic [1:0]            hv_q, hv_d;
  logic [AW:0]           hcnt_q [2];
  logic [AW:0]           hcnt_d [2];
  logic                  fh_q, fh_d, ph_q, ph_d;
  logic                  frd_q, frd_d, eod_q, eod_d;
  logic                  pend_q, pend_d;
  logic [AW:0]           widx_q, widx_d;
  logic [AW-1:0]         pidx_q, pidx_d;
  logic [TW-1:0]         to_q, to_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [CNT_W-1:0]      ovr_q, ovr_d, udr_q, udr_d;
`ifdef VOICE_SCHED_LOOP_EN
  logic                  filled_q, filled_d;
`endif

  logic [DATA_WIDTH-1:0] wbuf_q [2*WAVE_SIZE];
  logic [AW:0]           waddr, raddr, cnt;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rec_ready, f_wr, wr_en, tmo;

  assign waddr     = {fh_q, widx_q[AW-1:0]};
  assign raddr     = {ph_q, pidx_q};
  assign rd_word   = wbuf_q[raddr];
  assign cnt       = widx_q + {{AW{1'b0}}, i_f_rd_ef};
  assign tmo       = frd_q & ~i_f_rd_ef & (to_q == TO_MAX);
  assign rec_ready = (state_q == S_REC) & ~i_f_cach_full;
  assign f_wr      = rec_ready & i_rec_valid;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    hv_d    = hv_q;
    hcnt_d  = hcnt_q;
    fh_d    = fh_q;
    ph_d    = ph_q;
    frd_d   = frd_q;
    eod_d   = eod_q;
    pend_d  = 1'b0;
    widx_d  = widx_q;
    pidx_d  = pidx_q;
    to_d    = to_q;
    pdata_d = pdata_q;
    ovr_d   = ovr_q;
    udr_d   = udr_q;
    wr_en   = 1'b0;
`ifdef VOICE_SCHED_LOOP_EN
    filled_d = filled_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        priority case (1'b1)
          i_cmd_stop: begin end
          i_cmd_rec:  state_d = S_REC;
          i_cmd_play: begin
            state_d = S_REWIND;
            rw_d    = '0;
            hv_d    = '0;
            fh_d    = 1'b0;
            ph_d    = 1'b0;
            pidx_d  = '0;
            widx_d  = '0;
            frd_d   = 1'b0;
            eod_d   = 1'b0;
`ifdef VOICE_SCHED_LOOP_EN
            filled_d = 1'b0;
`endif
          end
          default: begin end
        endcase
      end
      S_REC: begin
        if (i_rec_valid && i_f_cach_full && !(&ovr_q))
          ovr_d = ovr_q + 1'b1;
      end
      S_REWIND: begin
        rw_d = rw_q + 2'd1;
        if (rw_q == 2'd3)
          state_d = S_PLAY;
      end
      S_PLAY: begin
        if (frd_q) begin
          widx_d = cnt;
          if (i_f_rd_ef) begin
            wr_en = 1'b1;
            to_d  = '0;
`ifdef VOICE_SCHED_LOOP_EN
            filled_d = 1'b1;
`endif
          end else if (!tmo) begin
            to_d = to_q + 1'b1;
          end
          if (i_f_rd_done || cnt == WS_C || tmo) begin
            frd_d  = 1'b0;
            widx_d = '0;
            if (tmo && cnt == '0) begin
`ifdef VOICE_SCHED_LOOP_EN
              if (filled_q) begin
                state_d  = S_REWIND;
                rw_d     = '0;
                filled_d = 1'b0;
              end else begin
                eod_d = 1'b1;
              end
`else
              eod_d = 1'b1;
`endif
            end else begin
              hcnt_d[fh_q] = cnt;
              hv_d[fh_q]   = 1'b1;
              fh_d         = ~fh_q;
            end
          end
        end else if (!hv_q[fh_q] && !eod_q) begin
          frd_d  = 1'b1;
          to_d   = '0;
          widx_d = '0;
        end
        // Drain side only touches hv[ph]; fill only sets an empty half
        if (i_play_tick) begin
          if (hv_q[ph_q]) begin
            pdata_d = ({1'b0, pidx_q} < hcnt_q[ph_q]) ? rd_word : '0;
            if (&pidx_q) begin
              hv_d[ph_q] = 1'b0;
              ph_d       = ~ph_q;
              pidx_d     = '0;
            end else begin
              pidx_d = pidx_q + 1'b1;
            end
          end else begin
            pdata_d = '0;
            if (!eod_q && !(&udr_q))
              udr_d = udr_q + 1'b1;
          end
        end
        if (eod_q && hv_q == 2'b00 && !frd_q) begin
          pend_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_cmd_stop) begin
      state_d = S_IDLE;
      frd_d   = 1'b0;
      hv_d    = '0;
      pdata_d = '0;
      eod_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rw_q      <= '0;
      hv_q      <= '0;
      hcnt_q[0] <= '0;
      hcnt_q[1] <= '0;
      fh_q      <= 1'b0;
      ph_q      <= 1'b0;
      frd_q     <= 1'b0;
      eod_q     <= 1'b0;
      pend_q    <= 1'b0;
      widx_q    <= '0;
      pidx_q    <= '0;
      to_q      <= '0;
      pdata_q   <= '0;
      ovr_q     <= '0;
      udr_q     <= '0;
`ifdef VOICE_SCHED_LOOP_EN
      filled_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      hv_q      <= hv_d;
      hcnt_q    <= hcnt_d;
      fh_q      <= fh_d;
      ph_q      <= ph_d;
      frd_q     <= frd_d;
      eod_q     <= eod_d;
      pend_q    <= pend_d;
      widx_q    <= widx_d;
      pidx_q    <= pidx_d;
      to_q      <= to_d;
      pdata_q   <= pdata_d;
      ovr_q     <= ovr_d;
      udr_q     <= udr_d;
`ifdef VOICE_SCHED_LOOP_EN
      filled_q  <= filled_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      wbuf_q[waddr] <= i_f_rd_data;
  end

  assign o_rec_ready   = rec_ready;
  assign o_f_wr        = f_wr;
  assign o_f_wr_data   = f_wr ? i_rec_data : '0;
  assign o_busy        = (state_q != S_IDLE);
  assign o_f_cls_raddr = (state_q == S_REWIND);
  assign o_f_rd        = frd_q;
  assign o_play_data   = pdata_q;
  assign o_play_end    = pend_q;
  assign o_ovr_cnt     = ovr_q;
  assign o_udr_cnt     = udr_q;

endmodule

// File: tb/tb_voice_wave_sched.sv
// Bench for voice_wave_sched: behavioural FIFO plus expected sample streams.
// Define VOICE_SCHED_LOOP_EN to exercise the replay build.
module tb_voice_wave_sched;
  localparam int WS = 32;
  localparam int DW = 16;
  localparam int TO = 256;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cmd_rec, cmd_play, cmd_stop;
  logic          rec_valid, rec_ready, play_tick, busy, play_end;
  logic [DW-1:0] rec_data, play_data, f_wr_data, f_rd_data;
  logic [CW-1:0] ovr_cnt, udr_cnt;
  logic          f_wr, cach_full, f_rd, f_cls, f_rd_ef, f_rd_done;

  voice_wave_sched dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_rec(cmd_rec), .i_cmd_play(cmd_play), .i_cmd_stop(cmd_stop),
    .i_rec_valid(rec_valid), .i_rec_data(rec_data), .o_rec_ready(rec_ready),
    .i_play_tick(play_tick), .o_play_data(play_data),
    .o_busy(busy), .o_play_end(play_end),
    .o_ovr_cnt(ovr_cnt), .o_udr_cnt(udr_cnt),
    .o_f_wr(f_wr), .o_f_wr_data(f_wr_data), .i_f_cach_full(cach_full),
    .o_f_rd(f_rd), .o_f_cls_raddr(f_cls),
    .i_f_rd_data(f_rd_data), .i_f_rd_ef(f_rd_ef), .i_f_rd_done(f_rd_done)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fmem [1024];
  int fifo_n = 0, fifo_slow = 0;
  int rptr = 0, dlv = 0, gap = 0;
  int pc = 0, last_ef_pc = 0, fall_pc = 0;
  int fall_seen = 0, cls_cyc = 0, pend_cnt = 0;
  logic frd_prev = 1'b0;

  always @(posedge clk) pc++;

  // FIFO: one wave per request, words in order, cls rewinds the pointer
  always @(negedge clk) begin
    f_rd_ef   = 1'b0;
    f_rd_done = 1'b0;
    if (!rst_n) begin
      rptr = 0; dlv = 0; gap = 0;
    end else begin
      if (f_cls) rptr = 0;
      if (!f_rd) begin
        dlv = 0; gap = 0;
      end else if (dlv < WS && rptr < fifo_n) begin
        gap++;
        if ((fifo_slow > 0) ? (gap >= fifo_slow) : ($urandom_range(3) != 0)) begin
          gap = 0;
          f_rd_ef = 1'b1;
          f_rd_data = fmem[rptr];
          rptr++; dlv++;
          f_rd_done = (dlv == WS);
          last_ef_pc = pc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (f_cls) cls_cyc++;
    if (play_end) pend_cnt++;
    if (frd_prev && !f_rd) begin
      fall_seen++;
      fall_pc = pc;
    end
    frd_prev = f_rd;
  end

  task automatic pulse_cmd(input int which);
    cmd_rec  = (which == 0);
    cmd_play = (which == 1);
    cmd_stop = (which == 2);
    @(negedge clk);
    cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic do_tick(input int idle, output logic [DW-1:0] v);
    for (int g = 0; g < 20 && f_cls; g++) @(negedge clk);
    play_tick = 1'b1;
    @(negedge clk);
    play_tick = 1'b0;
    v = play_data;
    repeat (idle) @(negedge clk);
  endtask

  task automatic test_reset;
    tests++;
    if ({busy, f_wr, f_rd, f_cls, rec_ready, play_end} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 000000",
               {busy, f_wr, f_rd, f_cls, rec_ready, play_end});
    end
    tests++;
    if (ovr_cnt !== 0 || udr_cnt !== 0 || play_data !== 0) begin
      fails++;
      $display("FAIL reset_data: ovr %0d udr %0d pd %0h want 0", ovr_cnt, udr_cnt, play_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pulse_cmd(0);
    rec_valid = 1'b1;
    rec_data = DW'($urandom);
    #1;
    tests++;
    if (busy !== 1'b1 || f_wr !== 1'b1) begin
      fails++;
      $display("FAIL rec_enter: busy %b wr %b want 1 1", busy, f_wr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 0 || f_wr !== 0 || rec_ready !== 0 || f_wr_data !== 0) begin
      fails++;
      $display("FAIL reset_mid_rec: busy %b wr %b rdy %b d %0h want 0",
               busy, f_wr, rec_ready, f_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 0 || f_wr !== 0) begin
      fails++;
      $display("FAIL after_reset: busy %b wr %b want 0 0", busy, f_wr);
    end
    rec_valid = 1'b0;
  endtask

  task automatic test_record;
    int nwr = 0;
    logic full;
    pulse_cmd(0);
    for (int i = 0; i < 100; i++) begin
      full = (i >= 40 && i < 50);
      rec_valid = 1'b1;
      rec_data = DW'($urandom);
      cach_full = full;
      #1;
      tests++;
      if (f_wr !== !full || rec_ready !== !full ||
          (!full && f_wr_data !== rec_data)) begin
        fails++;
        $display("FAIL rec_%0d: wr %b rdy %b d %0h want %b %b %0h",
                 i, f_wr, rec_ready, f_wr_data, !full, !full, rec_data);
      end
      if (f_wr) nwr++;
      @(negedge clk);
    end
    rec_valid = 1'b0;
    cach_full = 1'b0;
    @(negedge clk);
    tests++;
    if (nwr != 90) begin
      fails++;
      $display("FAIL rec_writes: got %0d want 90", nwr);
    end
    tests++;
    if (ovr_cnt !== 8'd10) begin
      fails++;
      $display("FAIL ovr_cnt: got %0d want 10", ovr_cnt);
    end
    pulse_cmd(2);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rec_stop: busy %b want 0", busy);
    end
  endtask

  task automatic test_play64;
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) fmem[i] = DW'($urandom);
    fifo_n = 64; fifo_slow = 0;
    cls_cyc = 0; pend_cnt = 0;
    pulse_cmd(1);
    repeat (150) @(negedge clk);
    tests++;
    if (cls_cyc != 4) begin
      fails++;
      $display("FAIL cls_burst: got %0d cycles want 4", cls_cyc);
    end
    for (int k = 0; k < 64; k++) begin
      do_tick(10, v);
      tests++;
      if (v !== fmem[k]) begin
        fails++;
        $display("FAIL play64_%0d: got %0h want %0h", k, v, fmem[k]);
      end
    end
    tests++;
    if (udr_cnt !== 0) begin
      fails++;
      $display("FAIL play64_udr: got %0d want 0", udr_cnt);
    end
`ifdef VOICE_SCHED_LOOP_EN
    tests++;
    if (cls_cyc != 8) begin
      fails++;
      $display("FAIL loop_cls: got %0d cycles want 8", cls_cyc);
    end
    for (int k = 0; k < 64; k++) begin
      do_tick(10, v);
      tests++;
      if (v !== fmem[k]) begin
        fails++;
        $display("FAIL replay_%0d: got %0h want %0h", k, v, fmem[k]);
      end
    end
    tests++;
    if (pend_cnt != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL loop_end: pend %0d busy %b want 0 1", pend_cnt, busy);
    end
    pulse_cmd(2);
`else
    for (int i = 0; i < 400 && pend_cnt == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    tests++;
    if (pend_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL play_end: pulses %0d busy %b want 1 0", pend_cnt, busy);
    end
`endif
  endtask

  task automatic test_timeout;
    logic [DW-1:0] v, exp;
    for (int i = 0; i < 20; i++) fmem[i] = DW'($urandom);
    fifo_n = 20; fifo_slow = 0;
    pend_cnt = 0;
    pulse_cmd(1);
    fall_seen = 0;
    for (int i = 0; i < 600 && fall_seen == 0; i++) @(negedge clk);
    tests++;
    if (fall_seen == 0 || fall_pc - last_ef_pc != TO) begin
      fails++;
      $display("FAIL timeout_len: seen %0d got %0d want %0d",
               fall_seen, fall_pc - last_ef_pc, TO);
    end
    for (int k = 0; k < 32; k++) begin
      do_tick(1, v);
      exp = (k < 20) ? fmem[k] : '0;
      tests++;
      if (v !== exp) begin
        fails++;
        $display("FAIL partial_%0d: got %0h want %0h", k, v, exp);
      end
    end
    tests++;
    if (udr_cnt !== 0) begin
      fails++;
      $display("FAIL partial_udr: got %0d want 0", udr_cnt);
    end
`ifndef VOICE_SCHED_LOOP_EN
    for (int i = 0; i < 600 && pend_cnt == 0; i++) @(negedge clk);
    tests++;
    if (pend_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL partial_end: pulses %0d busy %b want 1 0", pend_cnt, busy);
    end
`endif
    pulse_cmd(2);
  endtask

  task automatic test_starve;
    logic [DW-1:0] v;
    int z = 0, idx = 0, exp;
    for (int i = 0; i < 800; i++) fmem[i] = DW'($urandom) | DW'(1);
    fifo_n = 800; fifo_slow = 8;
    pulse_cmd(1);
    for (int k = 0; k < 1000; k++) begin
      do_tick(2, v);
      if (v == 0) begin
        z++;
      end else begin
        tests++;
        if (v !== fmem[idx]) begin
          fails++;
          $display("FAIL starve_data_%0d: got %0h want %0h", idx, v, fmem[idx]);
        end
        idx++;
      end
      if (k == 99) begin
        tests++;
        if (udr_cnt !== CW'(z)) begin
          fails++;
          $display("FAIL udr_count: got %0d want %0d", udr_cnt, z);
        end
      end
    end
    exp = (z > 255) ? 255 : z;
    tests++;
    if (udr_cnt !== CW'(exp) || udr_cnt !== 8'hff) begin
      fails++;
      $display("FAIL udr_sat: got %0d want %0d (starved %0d)", udr_cnt, exp, z);
    end
    tests++;
    if (idx < 100) begin
      fails++;
      $display("FAIL starve_flow: got %0d samples want >= 100", idx);
    end
    pulse_cmd(2);
  endtask

  task automatic test_stop;
    logic [DW-1:0] v;
    logic [CW-1:0] u;
    for (int i = 0; i < 64; i++) fmem[i] = DW'($urandom);
    fifo_n = 64; fifo_slow = 8;
    pulse_cmd(1);
    repeat (50) @(negedge clk);
    tests++;
    if (f_rd !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stop_pre: rd %b busy %b want 1 1", f_rd, busy);
    end
    pulse_cmd(2);
    tests++;
    if (busy !== 0 || f_rd !== 0 || f_cls !== 0 || play_data !== 0) begin
      fails++;
      $display("FAIL stop: busy %b rd %b cls %b pd %0h want 0",
               busy, f_rd, f_cls, play_data);
    end
    u = udr_cnt;
    do_tick(2, v);
    tests++;
    if (v !== 0 || udr_cnt !== u) begin
      fails++;
      $display("FAIL idle_tick: pd %0h udr %0d want 0 %0d", v, udr_cnt, u);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    rec_valid = 1'b0; rec_data = '0; cach_full = 1'b0;
    play_tick = 1'b0; f_rd_ef = 1'b0; f_rd_done = 1'b0; f_rd_data = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_record;
    test_play64;
    test_timeout;
    test_starve;
    test_stop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
